// File: rtl/sirv_uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity-mode constants and
// the default baud divisor width. Used by both the TX and RX blocks.
package sirv_uart_pkg;

    // Default width of the baud divisor.
    localparam int UART_DIV_W = 16;

    // Frame FSM states. The encodings are fixed because the RX block shares them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Bit positions within the io_parity control field.
    localparam int PARITY_EN_IDX  = 0;
    localparam int PARITY_ODD_IDX = 1;

    // Parity modes as driven on io_parity.
    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b11;

endpackage

// File: rtl/sirv_uart_fifo.sv
// Synchronous FIFO built from a flop array. The pointers wrap modulo DEPTH,
// and a separate occupancy count tells full from empty. A push is refused
// while the FIFO is full, even when a pop happens in the same cycle.
module sirv_uart_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop && !empty;
    assign head       = mem[rptr];

    // Storage array: write the pushed word at the write pointer.
    // NOTE: the data array has no reset; valid entries are tracked by count, so resetting it would only cost flops.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sirv_uarttx_fifo_gen.sv
// UART transmitter with an integrated TX FIFO. Frames are sent LSB first with
// one start bit, DATA_W data bits, an optional parity bit and 1 or 2 stop bits.
// Every bit lasts io_div+1 clocks. The idle line is high.
// Build option: define SIRV_UARTTX_PARITY_EN to build the parity state and
// honour io_parity; otherwise io_parity is ignored.
module sirv_uarttx_fifo_gen
    import sirv_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = UART_DIV_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_en,
    input  logic                         io_in_valid,
    output logic                         io_in_ready,
    input  logic [DATA_W-1:0]            io_in_bits,
    input  logic [DIV_W-1:0]             io_div,
    input  logic                         io_nstop,
    input  logic [1:0]                   io_parity,
    output logic [$clog2(FIFO_DEPTH):0]  io_count,
    output logic                         io_busy,
    output logic                         io_out
);
    localparam int BIT_W = $clog2(DATA_W);

    uart_state_e       state_q, state_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              stop2_q, stop2_d;
    logic              stop_left_q, stop_left_d;
    logic              out_q, out_d;
    logic              start_frame;
    logic              tick;
    logic              start_ok;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    sirv_uart_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (io_in_valid),
        .push_ready (io_in_ready),
        .push_data  (io_in_bits),
        .pop        (start_frame),
        .head       (fifo_head),
        .count      (io_count),
        .empty      (fifo_empty)
    );

    assign tick     = (state_q != ST_IDLE) && (presc_q == '0);
    assign start_ok = io_en && !fifo_empty;
    assign io_busy  = (state_q != ST_IDLE);
    assign io_out   = out_q;

`ifdef SIRV_UARTTX_PARITY_EN
    logic par_on_q;
    logic par_bit_q;

    // Parity mode and parity bit are captured when the frame's byte is popped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_on_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (start_frame) begin
            par_on_q  <= io_parity[PARITY_EN_IDX];
            par_bit_q <= (^fifo_head) ^ io_parity[PARITY_ODD_IDX];
        end
    end
`else
    logic parity_unused;
    assign parity_unused = ^io_parity;
`endif

    // Next-state, prescaler, shifter and registered txd value.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        presc_d     = presc_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        stop2_d     = stop2_q;
        stop_left_d = stop_left_q;
        out_d       = out_q;
        start_frame = 1'b0;

        if (state_q != ST_IDLE) begin
            presc_d = tick ? io_div : presc_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                start_frame = start_ok;
            end
            ST_START: begin
                if (tick) begin
                    state_d  = ST_DATA;
                    bitcnt_d = BIT_W'(DATA_W - 1);
                    out_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bitcnt_q == '0) begin
`ifdef SIRV_UARTTX_PARITY_EN
                        if (par_on_q) begin
                            state_d = ST_PARITY;
                            out_d   = par_bit_q;
                        end else
`endif
                        begin
                            state_d     = ST_STOP;
                            out_d       = 1'b1;
                            stop_left_d = stop2_q;
                        end
                    end else begin
                        shift_d  = shift_q >> 1;
                        bitcnt_d = bitcnt_q - 1'b1;
                        out_d    = shift_q[1];
                    end
                end
            end
`ifdef SIRV_UARTTX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d     = ST_STOP;
                    out_d       = 1'b1;
                    stop_left_d = stop2_q;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (stop_left_q) begin
                        stop_left_d = 1'b0;
                    end else if (start_ok) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b1;
            end
        endcase

        // Frame start from IDLE or straight out of STOP: pop the head and latch frame options.
        if (start_frame) begin
            state_d = ST_START;
            presc_d = io_div;
            shift_d = fifo_head;
            stop2_d = io_nstop;
            out_d   = 1'b0;
        end
    end

    // State register; reset forces the line high immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            stop2_q     <= 1'b0;
            stop_left_q <= 1'b0;
            out_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            stop2_q     <= stop2_d;
            stop_left_q <= stop_left_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_sirv_uarttx_fifo_gen.sv
// Directed testbench for sirv_uarttx_fifo_gen (DATA_W=8, FIFO_DEPTH=8).
// The txd line is sampled every clock, 1 time unit after the rising edge.
module tb_sirv_uarttx_fifo_gen;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int DIV_W  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_en;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [DATA_W-1:0] io_in_bits;
    logic [DIV_W-1:0]  io_div;
    logic              io_nstop;
    logic [1:0]        io_parity;
    logic [3:0]        io_count;
    logic              io_busy;
    logic              io_out;

    int tests_run    = 0;
    int tests_failed = 0;

    sirv_uarttx_fifo_gen #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_en       (io_en),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_in_bits  (io_in_bits),
        .io_div      (io_div),
        .io_nstop    (io_nstop),
        .io_parity   (io_parity),
        .io_count    (io_count),
        .io_busy     (io_busy),
        .io_out      (io_out)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        io_in_valid = 1'b1;
        io_in_bits  = b;
        tick();
        io_in_valid = 1'b0;
    endtask

    task automatic check_status(input string name, input logic exp_out, input logic exp_busy,
                                input logic [3:0] exp_count);
        tests_run++;
        if (io_out !== exp_out || io_busy !== exp_busy || io_count !== exp_count) begin
            tests_failed++;
            $display("FAIL %s: out=%b busy=%b count=%0d, required out=%b busy=%b count=%0d",
                     name, io_out, io_busy, io_count, exp_out, exp_busy, exp_count);
        end
    endtask

    task automatic wait_start(input string name, input int max_cycles);
        int n;
        n = 0;
        while (io_out !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        tests_run++;
        if (io_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: no start bit within %0d cycles, io_out=%b required 0",
                     name, max_cycles, io_out);
        end
    endtask

    // Checks one whole frame cycle by cycle, starting at the first sample of its start bit.
    // chg_bit: at the first cycle of this bit index io_div becomes new_div (-1: never).
    // drop_bit: at the first cycle of this bit index io_en is cleared (-1: never).
    task automatic check_frame(input string name, input logic [7:0] data, input int div,
                               input bit two_stop, input bit par_on, input bit par_bit,
                               input int chg_bit, input int new_div, input int drop_bit);
        logic exp_bits [0:11];
        int   n;
        int   len;
        n = 0;
        exp_bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            exp_bits[n] = data[i]; n++;
        end
        if (par_on) begin
            exp_bits[n] = par_bit; n++;
        end
        exp_bits[n] = 1'b1; n++;
        if (two_stop) begin
            exp_bits[n] = 1'b1; n++;
        end
        for (int b = 0; b < n; b++) begin
            if (b == chg_bit)  io_div = DIV_W'(new_div);
            if (b == drop_bit) io_en  = 1'b0;
            len = (chg_bit >= 0 && b > chg_bit) ? new_div + 1 : div + 1;
            for (int k = 0; k < len; k++) begin
                tests_run++;
                if (io_out !== exp_bits[b]) begin
                    tests_failed++;
                    $display("FAIL %s: bit %0d cycle %0d io_out=%b required %b",
                             name, b, k, io_out, exp_bits[b]);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        io_en       = 1'b0;
        io_in_valid = 1'b0;
        io_in_bits  = '0;
        io_div      = 16'd3;
        io_nstop    = 1'b0;
        io_parity   = 2'b00;
        #12;
        check_status("reset_held", 1'b1, 1'b0, 4'd0);
        tests_run++;
        if (io_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: io_in_ready=%b required 1", io_in_ready);
        end
        tick();
        reset = 1'b0;
        tick();
        check_status("reset_released", 1'b1, 1'b0, 4'd0);
    endtask

    task automatic test_basic_frame();
        io_en  = 1'b1;
        io_div = 16'd3;
        push_byte(8'hA5);
        check_status("latency_cycle1", 1'b1, 1'b0, 4'd1);
        tick();
        check_status("latency_cycle2", 1'b0, 1'b1, 4'd0);
        check_frame("frame_a5", 8'hA5, 3, 1'b0, 1'b0, 1'b0, -1, 0, -1);
        check_status("basic_idle", 1'b1, 1'b0, 4'd0);
    endtask

    task automatic test_fifo_full();
        logic [7:0] d [8];
        d = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h3C, 8'hC3};
        io_en  = 1'b0;
        io_div = 16'd1;
        for (int i = 0; i < 8; i++) push_byte(d[i]);
        check_status("full_count8", 1'b1, 1'b0, 4'd8);
        tests_run++;
        if (io_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ready: io_in_ready=%b required 0", io_in_ready);
        end
        push_byte(8'hEE);
        check_status("full_refused", 1'b1, 1'b0, 4'd8);
        io_en = 1'b1;
        wait_start("full_first_start", 4);
        for (int i = 0; i < 8; i++) begin
            check_frame($sformatf("b2b_frame%0d", i), d[i], 1, 1'b0, 1'b0, 1'b0, -1, 0, -1);
        end
        check_status("full_drained", 1'b1, 1'b0, 4'd0);
    endtask

    task automatic test_en_drop();
        io_en  = 1'b1;
        io_div = 16'd1;
        push_byte(8'h96);
        // This push lands in the same cycle as the pop of 0x96.
        push_byte(8'h69);
        check_status("push_pop_same_cycle", 1'b0, 1'b1, 4'd1);
        check_frame("en_drop_frame", 8'h96, 1, 1'b0, 1'b0, 1'b0, -1, 0, 3);
        for (int i = 0; i < 6; i++) begin
            check_status($sformatf("en_drop_idle%0d", i), 1'b1, 1'b0, 4'd1);
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        io_en = 1'b1;
        wait_start("resume_start", 4);
        for (int i = 0; i < 5; i++) tick();
        check_status("pre_reset_busy", io_out, 1'b1, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        check_status("reset_mid_frame", 1'b1, 1'b0, 4'd0);
        tests_run++;
        if (io_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_ready: io_in_ready=%b required 1", io_in_ready);
        end
        tick();
        reset  = 1'b0;
        io_div = 16'd2;
        tick();
        check_status("after_reset_idle", 1'b1, 1'b0, 4'd0);
        push_byte(8'h3C);
        wait_start("after_reset_start", 4);
        check_frame("after_reset_frame", 8'h3C, 2, 1'b0, 1'b0, 1'b0, -1, 0, -1);
    endtask

    task automatic test_div_change();
        io_en  = 1'b1;
        io_div = 16'd3;
        push_byte(8'h5A);
        wait_start("div_change_start", 4);
        check_frame("div_change_frame", 8'h5A, 3, 1'b0, 1'b0, 1'b0, 2, 1, -1);
        check_status("div_change_idle", 1'b1, 1'b0, 4'd0);
    endtask

`ifdef SIRV_UARTTX_PARITY_EN
    task automatic test_parity();
        io_en     = 1'b1;
        io_div    = 16'd1;
        io_nstop  = 1'b0;
        io_parity = 2'b01;
        push_byte(8'h07);
        wait_start("par_even_start", 4);
        check_frame("par_even_frame", 8'h07, 1, 1'b0, 1'b1, 1'b1, -1, 0, -1);
        io_parity = 2'b11;
        io_nstop  = 1'b1;
        push_byte(8'h07);
        wait_start("par_odd_start", 4);
        check_frame("par_odd_2stop_frame", 8'h07, 1, 1'b1, 1'b1, 1'b0, -1, 0, -1);
        check_status("parity_idle", 1'b1, 1'b0, 4'd0);
        io_parity = 2'b00;
        io_nstop  = 1'b0;
    endtask
`else
    task automatic test_parity();
        io_en     = 1'b1;
        io_div    = 16'd1;
        io_nstop  = 1'b1;
        io_parity = 2'b11;
        push_byte(8'h07);
        wait_start("no_par_start", 4);
        check_frame("no_par_2stop_frame", 8'h07, 1, 1'b1, 1'b0, 1'b0, -1, 0, -1);
        check_status("no_par_idle", 1'b1, 1'b0, 4'd0);
        io_parity = 2'b00;
        io_nstop  = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_fifo_full();
        test_en_drop();
        test_reset_mid_frame();
        test_div_change();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
